outport_credit_scheduler: RTL

//  Per-output-port scheduler for the lancetfish router. Arbitrates round-robin

---
 rtl/outport_credit_scheduler_pkg.sv | 20 ++
 rtl/outport_credit_scheduler_rr_pick.sv | 35 +++
 rtl/outport_credit_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/outport_credit_scheduler_pkg.sv
// Shared constants and types for the lancetfish output-port scheduler and its
// round-robin picker.
package outport_credit_scheduler_pkg;

    localparam int DEFAULT_N_REQ        = 4;
    localparam int DEFAULT_BUFFER_DEPTH = 4;
    localparam int DEFAULT_PACKET_FLITS = 4;
    localparam int CHANNEL_WIDTH        = 32;

    typedef enum logic {
        SCHED_IDLE   = 1'b0,
        SCHED_ACTIVE = 1'b1
    } sched_state_e;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/outport_credit_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping modulo N. Shared with the input-side VC allocator.
module outport_credit_scheduler_rr_pick
    import outport_credit_scheduler_pkg::*;
#(
    parameter int N  = DEFAULT_N_REQ,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [N-1:0]  winner_onehot,
    output logic [IW-1:0] winner_idx
);

    logic [IW-1:0] cand;

    always_comb begin
        valid         = 1'b0;
        winner_idx    = '0;
        winner_onehot = '0;
        cand          = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!valid && req[cand]) begin
                valid      = 1'b1;
                winner_idx = cand;
            end
        end
        if (valid) begin
            winner_onehot[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/outport_credit_scheduler.sv
// Per-output-channel scheduler: round-robin packet arbitration with the grant
// held for a whole packet, and flit pacing by a downstream credit counter.
module outport_credit_scheduler
    import outport_credit_scheduler_pkg::*;
#(
    parameter int N_REQ        = DEFAULT_N_REQ,
    parameter int BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH,
    parameter int PACKET_FLITS = DEFAULT_PACKET_FLITS,
    parameter int CW           = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] request_din,
    input  logic             credit_in_din,
    output logic [N_REQ-1:0] grant_dout,
    output logic             xfer_dout,
    output logic [CW-1:0]    credits_dout,
    output logic             busy_dout,
    output logic             credit_overflow_dout
);

    localparam int IW = idx_width(N_REQ);
    localparam int FW = idx_width(PACKET_FLITS);

    localparam logic [CW-1:0] CREDIT_MAX = CW'(BUFFER_DEPTH);
    localparam logic [FW-1:0] LAST_FLIT  = FW'(PACKET_FLITS - 1);
    localparam logic [IW-1:0] LAST_REQ   = IW'(N_REQ - 1);

    sched_state_e     state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    winner;
    logic [FW-1:0]    flit_cnt;
    logic [CW-1:0]    credits;

    logic             pick_valid;
    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             last_flit;
    logic [IW-1:0]    next_ptr;

    outport_credit_scheduler_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req           (request_din),
        .ptr           (ptr),
        .valid         (pick_valid),
        .winner_onehot (pick_onehot),
        .winner_idx    (pick_idx)
    );

    // A flit moves in any ACTIVE cycle with a free downstream slot; the
    // upstream pops and the crossbar forwards on this strobe, no ready is
    // returned. Each moved flit consumes a credit, each credit_in pulse
    // returns one.
    assign xfer_dout    = (state == SCHED_ACTIVE) && (credits != '0);
    assign busy_dout    = (state == SCHED_ACTIVE);
    assign credits_dout = credits;

    assign last_flit = (flit_cnt == LAST_FLIT);
    assign next_ptr  = (winner == LAST_REQ) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SCHED_IDLE;
            grant_dout <= '0;
            ptr        <= '0;
            winner     <= '0;
            flit_cnt   <= '0;
        end else begin
            case (state)
                SCHED_IDLE: begin
                    if (pick_valid) begin
                        grant_dout <= pick_onehot;
                        winner     <= pick_idx;
                        flit_cnt   <= '0;
                        state      <= SCHED_ACTIVE;
                    end
                end
                SCHED_ACTIVE: begin
                    // Requests are not sampled here; the grant lasts the packet.
                    if (xfer_dout) begin
                        if (last_flit) begin
                            state      <= SCHED_IDLE;
                            grant_dout <= '0;
                            ptr        <= next_ptr;
                            flit_cnt   <= '0;
                        end else begin
                            flit_cnt <= flit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= SCHED_IDLE;
                    grant_dout <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits              <= CREDIT_MAX;
            credit_overflow_dout <= 1'b0;
        end else begin
            case ({xfer_dout, credit_in_din})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    // A return with every slot already free means the
                    // downstream and this mirror have drifted apart.
                    if (credits == CREDIT_MAX) begin
                        credit_overflow_dout <= 1'b1;
                    end else begin
                        credits <= credits + 1'b1;
                    end
                end
                default: credits <= credits;
            endcase
        end
    end

endmodule
